// File: rtl/return_stack_unit_pkg.sv
// rtl/return_stack_unit_pkg.sv - shared stack-command and FSM state encodings
package return_stack_unit_pkg;

    typedef logic [1:0] sp_cmd_t;

    // Stack commands issued by the control unit on SP_ADD
    localparam sp_cmd_t SP_HOLD = 2'b00;
    localparam sp_cmd_t SP_POP  = 2'b01;
    localparam sp_cmd_t SP_PUSH = 2'b10;
    localparam sp_cmd_t SP_RSVD = 2'b11;

    // Return-stack FSM states
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FAULT  = 1'b1;

endpackage

// File: rtl/rs_regfile.sv
// rtl/rs_regfile.sv - return-address storage, one sync write port, one async read port
module rs_regfile #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);

    logic [AW-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the stack count
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack_unit.sv
// rtl/return_stack_unit.sv - hardware return-address stack with overflow/underflow fault handling
module return_stack_unit
    import return_stack_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             SP_ADD,
    input  logic [AW-1:0]          push_addr,
    input  logic                   clear_err,
    output logic [AW-1:0]          ret_addr,
    output logic                   ret_valid,
    output logic [AW-1:0]          top_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow_err,
    output logic                   underflow_err,
    output logic                   fault
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    logic [0:0]    state;
    logic          active;
    logic          is_push;
    logic          is_pop;
    logic          push_ok;
    logic          pop_ok;
    logic          wr_en;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] rd_data;

    // Commands are only honoured in NORMAL; reserved/hold encodings decode to nothing
    assign active  = (state == ST_NORMAL) && en;
    assign is_push = active && (SP_ADD == SP_PUSH);
    assign is_pop  = active && (SP_ADD == SP_POP);
    assign push_ok = is_push && !full;
    assign pop_ok  = is_pop && !empty;
    assign wr_en   = push_ok && !reset;

    // Top of stack lives at count-1; a full stack wraps the index back to DEPTH-1
    assign wr_idx = count[IW-1:0];
    assign rd_idx = count[IW-1:0] - IDX_ONE;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign fault    = (state == ST_FAULT);
    assign top_addr = empty ? '0 : rd_data;

    rs_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (push_addr),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // Stack pointer, popped-address register, error flags and fault FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_NORMAL;
            count         <= '0;
            ret_addr      <= '0;
            ret_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            ret_valid <= 1'b0;
            if (state == ST_FAULT) begin
                if (clear_err) begin
                    overflow_err  <= 1'b0;
                    underflow_err <= 1'b0;
                    state         <= ST_NORMAL;
                end
            end else begin
                if (push_ok) begin
                    count <= count + CNT_ONE;
                end else if (is_push) begin
                    overflow_err <= 1'b1;
                    state        <= ST_FAULT;
                end
                if (pop_ok) begin
                    count     <= count - CNT_ONE;
                    ret_addr  <= rd_data;
                    ret_valid <= 1'b1;
                end else if (is_pop) begin
                    underflow_err <= 1'b1;
                    state         <= ST_FAULT;
                end
            end
        end
    end

endmodule

// File: tb/tb_return_stack_unit.sv
// tb/tb_return_stack_unit.sv - scoreboard bench for return_stack_unit
module tb_return_stack_unit;

    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    SP_ADD;
    logic [AW-1:0] push_addr;
    logic          clear_err;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic [AW-1:0] top_addr;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          overflow_err;
    logic          underflow_err;
    logic          fault;

    return_stack_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .SP_ADD        (SP_ADD),
        .push_addr     (push_addr),
        .clear_err     (clear_err),
        .ret_addr      (ret_addr),
        .ret_valid     (ret_valid),
        .top_addr      (top_addr),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t           evq[$];
    logic [AW-1:0] stk[$];
    logic [AW-1:0] m_ret;
    bit            m_ovf;
    bit            m_unf;
    bit            m_flt;
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, a pulse must match the scoreboard head or be absent
    always @(posedge clk) begin
        ev_t e;
        #1;
        cyc++;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            chk("ret_valid_pulse", 64'(ret_valid), 64'(1));
            chk("ret_addr_pulse", 64'(ret_addr), 64'(e.addr));
        end else if (cyc > 1) begin
            chk("ret_valid_idle", 64'(ret_valid), 64'(0));
        end
    end

    task automatic check_state();
        logic [AW-1:0] exp_top;
        exp_top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        chk("count", 64'(count), 64'(stk.size()));
        chk("top_addr", 64'(top_addr), 64'(exp_top));
        chk("empty", 64'(empty), 64'(stk.size() == 0));
        chk("full", 64'(full), 64'(stk.size() == DEPTH));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(m_unf));
        chk("fault", 64'(fault), 64'(m_flt));
        chk("ret_addr_hold", 64'(ret_addr), 64'(m_ret));
    endtask

    // Drive one cycle, advance the reference stack, then check the settled state
    task automatic step(input bit e, input logic [1:0] cmd, input logic [AW-1:0] a,
                        input bit clr, input bit rst);
        ev_t ev;
        en        = e;
        SP_ADD    = cmd;
        push_addr = a;
        clear_err = clr;
        reset     = rst;
        if (rst) begin
            stk.delete();
            m_ret = '0;
            m_ovf = 0;
            m_unf = 0;
            m_flt = 0;
        end else if (m_flt) begin
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
                m_flt = 0;
            end
        end else if (e && cmd == 2'b10) begin
            if (stk.size() == DEPTH) begin
                m_ovf = 1;
                m_flt = 1;
            end else begin
                stk.push_back(a);
            end
        end else if (e && cmd == 2'b01) begin
            if (stk.size() == 0) begin
                m_unf = 1;
                m_flt = 1;
            end else begin
                m_ret   = stk.pop_back();
                ev.cyc  = cyc + 1;
                ev.addr = m_ret;
                evq.push_back(ev);
            end
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        en        = 0;
        SP_ADD    = 2'b00;
        push_addr = '0;
        clear_err = 0;
        reset     = 1;
        @(negedge clk);

        step(0, 2'b00, 0, 0, 1);
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_ret_valid", 64'(ret_valid), 64'(0));

        step(1, 2'b10, 32'h10, 0, 0);
        step(1, 2'b10, 32'h20, 0, 0);
        step(1, 2'b10, 32'h30, 0, 0);
        chk("lifo_count3", 64'(count), 64'(3));
        chk("lifo_top", 64'(top_addr), 64'(32'h30));
        step(1, 2'b01, 0, 0, 0);
        chk("pop1_addr", 64'(ret_addr), 64'(32'h30));
        step(1, 2'b01, 0, 0, 0);
        chk("pop2_addr", 64'(ret_addr), 64'(32'h20));
        step(1, 2'b01, 0, 0, 0);
        chk("pop3_addr", 64'(ret_addr), 64'(32'h10));
        chk("pop3_valid", 64'(ret_valid), 64'(1));
        chk("lifo_empty", 64'(empty), 64'(1));

        for (int i = 0; i < 9; i++) step(1, 2'b10, 32'h100 + 32'(i), 0, 0);
        chk("ovf_full", 64'(full), 64'(1));
        chk("ovf_flag", 64'(overflow_err), 64'(1));
        chk("ovf_fault", 64'(fault), 64'(1));
        chk("ovf_count", 64'(count), 64'(8));
        chk("ovf_top", 64'(top_addr), 64'(32'h107));

        step(1, 2'b01, 0, 0, 0);
        chk("fault_pop_count", 64'(count), 64'(8));
        chk("fault_pop_valid", 64'(ret_valid), 64'(0));
        step(0, 2'b00, 0, 1, 0);
        chk("clear_fault", 64'(fault), 64'(0));
        chk("clear_ovf", 64'(overflow_err), 64'(0));
        step(1, 2'b01, 0, 0, 0);
        chk("post_clear_pop", 64'(ret_addr), 64'(32'h107));

        step(0, 2'b00, 0, 0, 1);
        step(1, 2'b01, 0, 0, 0);
        chk("unf_flag", 64'(underflow_err), 64'(1));
        chk("unf_valid", 64'(ret_valid), 64'(0));
        chk("unf_count", 64'(count), 64'(0));
        step(0, 2'b00, 0, 1, 0);

        for (int i = 0; i < 5; i++) step(0, 2'b10, 32'hdead, 0, 0);
        step(1, 2'b11, 32'hbeef, 0, 0);
        chk("idle_count", 64'(count), 64'(0));

        step(1, 2'b10, 32'h40, 0, 0);
        step(1, 2'b01, 0, 0, 1);
        chk("rst_pop_count", 64'(count), 64'(0));
        chk("rst_pop_valid", 64'(ret_valid), 64'(0));
        chk("rst_pop_top", 64'(top_addr), 64'(0));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0);
        end

        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        chk("scoreboard_drained", 64'(evq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
